// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: FSM encoding, instruction width, halt word and queue entry layout.
package fetch_ctrl_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // The ROM is word addressed; byte offset bits are dropped.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: ROM port, redirect from execute, and the instruction stream to decode.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [31:0]       rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [INST_W-1:0] out_inst;
    logic              halted;

    modport master (
        output rom_addr, out_valid, out_pc, out_inst, halted,
        input  rom_inst, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_pc, out_inst, halted,
        output rom_inst, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer with push/pop/flush and full/empty flags.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: caller must not push when full unless popping in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem[wr_ptr] <= wdat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight out of storage, never from the write data path.
    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through the ROM and queues {pc, inst} for decode.
// Latency: first instruction valid on the second edge after reset release or redirect.
// Backpressure: full queue with no pop stalls pc; redirect flushes and overrides everything.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  fif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         halted_q;

    logic         flush;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic         is_halt_word;
    fetch_entry_t wdat;
    fetch_entry_t head;

    assign flush        = fif.redirect_valid;
    assign is_halt_word = (fif.rom_inst == HALT_WORD);
    assign pop          = !empty && fif.out_ready && !flush;
    assign push         = (state == RUN) && !flush && !is_halt_word && (!full || pop);
    assign wdat         = {pc, fif.rom_inst};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            halted_q <= 1'b0;
        end else if (flush) begin
            state    <= RUN;
            pc       <= {fif.redirect_pc[31:2], 2'b00};
            halted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    // A zero word ends the program; pc stays on it so rom_addr points at the halt.
                    if (is_halt_word) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (push) begin
                        pc <= pc + 32'd4;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdat  (wdat),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign fif.rom_addr  = word_index(pc);
    assign fif.out_valid = !empty;
    assign fif.out_pc    = head.pc;
    assign fif.out_inst  = head.inst;
    assign fif.halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QD       = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if ifc();

    fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (ifc)
    );

    logic [31:0] rom [64];
    assign ifc.rom_inst = rom[ifc.rom_addr[5:0]];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: fetch pointer, decode-side queue, and run/halt flags.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_halt;

    task automatic rom_init();
        rom[0] = 32'h0380_000c;
        rom[1] = 32'h0380_040d;
        rom[2] = 32'h0380_0017;
        rom[3] = 32'h0380_0418;
        for (int i = 4; i < 64; i++) rom[i] = 32'h1357_0000 + 32'(i) * 32'h0000_0101;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = RESET_PC;
        m_run  = 1'b0;
        m_halt = 1'b0;
    endtask

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        logic [31:0] w;
        if (ifc.redirect_valid) begin
            m_q.delete();
            m_pc   = ifc.redirect_pc & ~32'd3;
            m_halt = 1'b0;
            m_run  = 1'b1;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (m_q.size() > 0 && ifc.out_ready) void'(m_q.pop_front());
            if (!m_halt) begin
                w = rom[m_pc[7:2]];
                if (w == 32'h0) m_halt = 1'b1;
                else if (m_q.size() < QD) begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0380_000c; exp_w[1] = 32'h0380_040d;
        exp_w[2] = 32'h0380_0017; exp_w[3] = 32'h0380_0418;
        rom_init();
        ifc.out_ready = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", ifc.out_valid); end
        n_cmp++; if (ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_head got %h/%h want 0/0", ifc.out_pc, ifc.out_inst); end
        n_cmp++; if (ifc.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", ifc.halted); end
        n_cmp++; if (ifc.rom_addr !== (RESET_PC >> 2)) begin n_bad++; $display("FAIL reset_rom_addr got %h want %h", ifc.rom_addr, RESET_PC >> 2); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL first_edge_valid got %b want 0", ifc.out_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'(i * 4) || ifc.out_inst !== exp_w[i]) begin
                n_bad++;
                $display("FAIL reset_stream[%0d] got v=%b %h/%h want v=1 %h/%h", i, ifc.out_valid, ifc.out_pc, ifc.out_inst, 32'(i * 4), exp_w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ifc.out_ready = 1'b0;
        repeat (6) step();
        n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h0380_000c) begin
            n_bad++; $display("FAIL bp_head got v=%b %h/%h want v=1 0/0380000c", ifc.out_valid, ifc.out_pc, ifc.out_inst); end
        n_cmp++; if (ifc.rom_addr !== 32'd2) begin n_bad++; $display("FAIL bp_pc_frozen got %h want 2", ifc.rom_addr); end
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'(i * 4) || ifc.out_inst !== rom[i]) begin
                n_bad++;
                $display("FAIL bp_release[%0d] got v=%b %h/%h want v=1 %h/%h", i, ifc.out_valid, ifc.out_pc, ifc.out_inst, 32'(i * 4), rom[i]);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ifc.out_ready = 1'b0;
        repeat (6) step();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0000_0027;
        ifc.out_ready      = 1'b1;
        step();
        ifc.redirect_valid = 1'b0;
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got v=%b want 0", ifc.out_valid); end
        n_cmp++; if (ifc.rom_addr !== 32'd9) begin n_bad++; $display("FAIL redir_target got %h want 9", ifc.rom_addr); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h24 + 32'(i * 4) || ifc.out_inst !== rom[9 + i]) begin
                n_bad++;
                $display("FAIL redir_stream[%0d] got v=%b %h/%h want v=1 %h/%h", i, ifc.out_valid, ifc.out_pc, ifc.out_inst, 32'h24 + 32'(i * 4), rom[9 + i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [31:0] last;
        last = 32'hDEAD_BEEF;
        do_reset();
        rom[12] = 32'h0;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (ifc.out_valid === 1'b1) last = ifc.out_pc;
            step();
        end
        n_cmp++; if (last !== 32'h2C) begin n_bad++; $display("FAIL halt_last_pc got %h want 2c", last); end
        n_cmp++; if (ifc.halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag got %b want 1", ifc.halted); end
        n_cmp++; if (ifc.rom_addr !== 32'd12) begin n_bad++; $display("FAIL halt_rom_addr got %h want c", ifc.rom_addr); end
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL halt_drained got v=%b want 0", ifc.out_valid); end
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0;
        step();
        ifc.redirect_valid = 1'b0;
        n_cmp++; if (ifc.halted !== 1'b0) begin n_bad++; $display("FAIL halt_clear got %b want 0", ifc.halted); end
        step();
        n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h0380_000c) begin
            n_bad++; $display("FAIL halt_restart got v=%b %h/%h want v=1 0/0380000c", ifc.out_valid, ifc.out_pc, ifc.out_inst); end
        rom[12] = 32'h1357_0000 + 32'd12 * 32'h0000_0101;
    endtask

    task automatic test_redirect_on_halt();
        int guard;
        guard = 0;
        do_reset();
        rom[12] = 32'h0;
        ifc.out_ready = 1'b1;
        while (!(m_run && m_pc == 32'h30) && guard < 40) begin
            step();
            guard++;
        end
        n_cmp++; if (guard >= 40 || ifc.rom_inst !== 32'h0) begin
            n_bad++; $display("FAIL rh_reach_zero got guard=%0d inst=%h want inst=0", guard, ifc.rom_inst); end
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0000_0040;
        step();
        ifc.redirect_valid = 1'b0;
        n_cmp++; if (ifc.halted !== 1'b0) begin n_bad++; $display("FAIL rh_halted got %b want 0", ifc.halted); end
        n_cmp++; if (ifc.rom_addr !== 32'h10) begin n_bad++; $display("FAIL rh_target got %h want 10", ifc.rom_addr); end
        step();
        n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h40 || ifc.out_inst !== rom[16] || ifc.halted !== 1'b0) begin
            n_bad++; $display("FAIL rh_fetch got v=%b %h/%h h=%b want v=1 40/%h h=0", ifc.out_valid, ifc.out_pc, ifc.out_inst, ifc.halted, rom[16]); end
        rom[12] = 32'h1357_0000 + 32'd12 * 32'h0000_0101;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        exp_in[0] = rom[62];       exp_in[1] = rom[63];       exp_in[2] = rom[0];
        do_reset();
        ifc.out_ready = 1'b1;
        repeat (3) step();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFA;
        step();
        ifc.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp_pc[i] || ifc.out_inst !== exp_in[i]) begin
                n_bad++;
                $display("FAIL wrap[%0d] got v=%b %h/%h want v=1 %h/%h", i, ifc.out_valid, ifc.out_pc, ifc.out_inst, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ifc.out_ready = 1'b1;
        repeat (5) step();
        n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre got v=%b want 1", ifc.out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h0) begin
            n_bad++; $display("FAIL areset_out got v=%b %h/%h want v=0 0/0", ifc.out_valid, ifc.out_pc, ifc.out_inst); end
        n_cmp++; if (ifc.rom_addr !== (RESET_PC >> 2) || ifc.halted !== 1'b0) begin
            n_bad++; $display("FAIL areset_pc got %h h=%b want %h h=0", ifc.rom_addr, ifc.halted, RESET_PC >> 2); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_no_partial got v=%b want 0", ifc.out_valid); end
        step();
        n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== RESET_PC || ifc.out_inst !== rom[0]) begin
            n_bad++; $display("FAIL areset_restart got v=%b %h/%h want v=1 %h/%h", ifc.out_valid, ifc.out_pc, ifc.out_inst, RESET_PC, rom[0]); end
    endtask

    task automatic test_random();
        rom_init();
        for (int k = 0; k < 4; k++) rom[$urandom_range(8, 63)] = 32'h0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            ifc.out_ready      = ($urandom_range(0, 3) != 0);
            ifc.redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) ifc.redirect_pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else                           ifc.redirect_pc = 32'($urandom_range(0, 255));
            step();
            n_cmp++;
            if (ifc.out_valid !== (m_q.size() > 0)) begin
                n_bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, ifc.out_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if (ifc.out_pc !== m_q[0][63:32] || ifc.out_inst !== m_q[0][31:0]) begin
                    n_bad++; $display("FAIL rnd_head c=%0d got %h/%h want %h/%h", c, ifc.out_pc, ifc.out_inst, m_q[0][63:32], m_q[0][31:0]);
                end
            end
            n_cmp++;
            if (ifc.halted !== m_halt) begin
                n_bad++; $display("FAIL rnd_halted c=%0d got %b want %b", c, ifc.halted, m_halt);
            end
            n_cmp++;
            if (ifc.rom_addr !== {2'b00, m_pc[31:2]}) begin
                n_bad++; $display("FAIL rnd_rom_addr c=%0d got %h want %h", c, ifc.rom_addr, {2'b00, m_pc[31:2]});
            end
        end
        ifc.redirect_valid = 1'b0;
    endtask

    initial begin
        ifc.out_ready      = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        rom_init();
        model_reset();
        #1;
        test_reset();
        test_backpressure();
        test_redirect();
        test_halt();
        test_redirect_on_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
